// File: rtl/maxpool_unit_pkg.sv
// Shared accelerator definitions: pixel width, default feature-map size and
// the pooling FSM state encoding.
package maxpool_unit_pkg;

  localparam int MP_DATA_W = 32;
  localparam int MP_FMAP_W = 6;
  localparam int MP_FMAP_H = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/maxpool_unit_max2.sv
// Signed two-input maximum; ties return the shared value.
module max2 #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);

  assign y = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool_unit.sv
// 2x2 stride-2 max pooling over a raster-order feature map, one row buffer of
// horizontal maxima, single registered output with valid/ready back-pressure.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting pixels until the last pixel of the map arrives
// ST_DRAIN | all pixels taken, waiting for the final pooled pixel to leave
// ST_DONE  | map finished, done high, start launches the next map
module maxpool_unit
  import maxpool_unit_pkg::*;
#(
  parameter int DATA_W = MP_DATA_W,
  parameter int FMAP_W = MP_FMAP_W,
  parameter int FMAP_H = MP_FMAP_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     done
);

  localparam int HALF_W = FMAP_W / 2;
  localparam int ROW_W  = $clog2(FMAP_H);
  localparam int COL_W  = $clog2(FMAP_W);
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);

  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic signed [DATA_W-1:0]  pair_q, pair_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic signed [DATA_W-1:0]  row_buf_q [HALF_W];
  logic signed [DATA_W-1:0]  row_buf_d [HALF_W];

  logic                      accept;
  logic                      out_fire;
  logic                      start_ok;
  logic                      last_pix;
  logic [IDX_W-1:0]          buf_idx;
  logic signed [DATA_W-1:0]  hmax;
  logic signed [DATA_W-1:0]  vmax;

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign buf_idx  = IDX_W'(col_q >> 1);

  max2 #(.DATA_W(DATA_W)) u_max_h (
    .a (pair_q),
    .b (in_data),
    .y (hmax)
  );

  max2 #(.DATA_W(DATA_W)) u_max_v (
    .a (row_buf_q[buf_idx]),
    .b (hmax),
    .y (vmax)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < HALF_W; i++) row_buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      row_buf_q   <= row_buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (accept && last_pix) state_d = ST_DRAIN;
      ST_DRAIN:         if (out_fire && out_last_q) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // in_ready already guarantees a new load never overwrites unconsumed data.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    pair_d      = pair_q;
    row_buf_d   = row_buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (start_ok) begin
      row_d = '0;
      col_d = '0;
    end

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0]) begin
        pair_d = in_data;
      end else if (!row_q[0]) begin
        row_buf_d[buf_idx] = hmax;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = vmax;
        out_last_d  = last_pix;
      end
    end
  end

  always_comb begin
    in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    done     = (state_q == ST_DONE);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_unit.sv
// Self-checking bench for maxpool_unit: randomized and directed maps compared
// against a window-maximum reference computed from the input image.
module tb_maxpool_unit;

  localparam int DW   = 32;
  localparam int W    = 6;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 done;

  int checks = 0;
  int errors = 0;

  int pix [NPIX];
  int exp_q [$];
  int got_q [$];
  bit last_q [$];

  int rdy_mode    = 0;
  int stall_left  = 0;
  bit stall_used  = 0;
  bit saw_ir_low  = 0;
  int cyc_cnt     = 0;
  int last_hs_cyc = -1;
  int done_rise   = -1;
  bit done_prev   = 0;

  always #5 clk = ~clk;

  maxpool_unit #(.DATA_W(DW), .FMAP_W(W), .FMAP_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  // Downstream: choose out_ready after each negedge, then log handshakes.
  always begin
    bit stalling;
    @(negedge clk);
    #1;
    stalling = 0;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (!stall_used && out_valid) begin
          stall_left = 10;
          stall_used = 1;
        end
        if (stall_left > 0) begin
          stalling   = 1;
          out_ready  = 1'b0;
          stall_left--;
          checks++;
          if (out_data !== 7) begin
            errors++;
            $display("FAIL stall_hold: out_data got %0d expected 7", out_data);
          end
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
    #1;
    cyc_cnt++;
    if (stalling && !in_ready) saw_ir_low = 1;
    if (out_valid && out_ready) begin
      got_q.push_back(int'(out_data));
      last_q.push_back(out_last);
      if (out_last) last_hs_cyc = cyc_cnt;
    end
    if (done && !done_prev) done_rise = cyc_cnt;
    done_prev = done;
  end

  function automatic void build_expected();
    exp_q.delete();
    for (int r = 0; r < H / 2; r++) begin
      for (int c = 0; c < W / 2; c++) begin
        int m;
        m = pix[(2 * r) * W + 2 * c];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (pix[(2 * r + dr) * W + 2 * c + dc] > m) m = pix[(2 * r + dr) * W + 2 * c + dc];
        exp_q.push_back(m);
      end
    end
  endfunction

  task automatic drive_map(input int gap, input int npix);
    int idx = 0;
    int cyc = 0;
    while (idx < npix && cyc < 40 * npix + 200) begin
      @(negedge clk);
      case (gap)
        0:       in_valid = 1'b1;
        1:       in_valid = ((cyc % 2) == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? pix[idx] : $urandom;
      #3;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (idx != npix) begin
      errors++;
      $display("FAIL drive_timeout: accepted %0d pixels expected %0d", idx, npix);
    end
  endtask

  task automatic run_map(input int gap, input int npix);
    got_q.delete();
    last_q.delete();
    last_hs_cyc = -1;
    done_rise   = -1;
    build_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_map(gap, npix);
  endtask

  task automatic check_results(input string name);
    int n = 0;
    while ((got_q.size() < NOUT || !done) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s_done_timeout: got %0d outputs done=%0b expected %0d and done=1", name, got_q.size(), done, NOUT);
    end
    checks++;
    if (got_q.size() != NOUT) begin
      errors++;
      $display("FAIL %s_count: got %0d expected %0d", name, got_q.size(), NOUT);
    end
    for (int i = 0; i < NOUT && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %0d expected %0d", name, i, got_q[i], exp_q[i]);
      end
      checks++;
      if (last_q[i] !== (i == NOUT - 1)) begin
        errors++;
        $display("FAIL %s_last[%0d]: got %0b expected %0b", name, i, last_q[i], (i == NOUT - 1));
      end
    end
    checks++;
    if (done_rise !== last_hs_cyc + 1 || last_hs_cyc < 0) begin
      errors++;
      $display("FAIL %s_done_timing: done rose at %0d expected %0d", name, done_rise, last_hs_cyc + 1);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) pix[i] = i;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++)
      pix[i] = ((i % 3) == 0) ? int'($urandom) : int'($urandom_range(0, 16)) - 8;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 0)    begin errors++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b expected 0", out_last); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %0b expected 0", done); end
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 99;
    repeat (3) begin
      @(negedge clk);
      #3;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %0b expected 0", in_ready); end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_output: got %0b expected 0", out_valid); end
  endtask

  task automatic test_ramp();
    rdy_mode = 0;
    fill_ramp();
    run_map(0, NPIX);
    check_results("ramp");
    checks++;
    if (exp_q.size() != NOUT || exp_q[0] != 7 || exp_q[NOUT - 1] != 35) begin
      errors++;
      $display("FAIL ramp_model: first %0d last %0d expected 7 and 35", exp_q[0], exp_q[NOUT - 1]);
    end
  endtask

  task automatic test_negative();
    rdy_mode = 0;
    for (int i = 0; i < NPIX; i++) pix[i] = -5;
    pix[3 * W + 2] = -1;
    run_map(0, NPIX);
    check_results("negative");
  endtask

  task automatic test_stall();
    rdy_mode   = 2;
    stall_used = 0;
    stall_left = 0;
    saw_ir_low = 0;
    fill_ramp();
    run_map(0, NPIX);
    check_results("stall");
    checks++;
    if (saw_ir_low !== 1'b1) begin
      errors++;
      $display("FAIL stall_in_ready: low during stall got %0b expected 1", saw_ir_low);
    end
    rdy_mode = 0;
  endtask

  task automatic test_gaps();
    rdy_mode = 0;
    fill_ramp();
    run_map(1, NPIX);
    check_results("gaps");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      rdy_mode = 1;
      fill_random();
      run_map(2, NPIX);
      check_results("random");
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    rdy_mode = 0;
    fill_random();
    run_map(0, 20);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 0)    begin errors++; $display("FAIL midrst_out_data: got %0d expected 0", out_data); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL midrst_done: got %0b expected 0", done); end
    @(negedge clk);
    rst = 1'b1;
    fill_ramp();
    run_map(0, NPIX);
    check_results("after_reset");
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0;
    fill_random();
    fork
      run_map(0, NPIX);
      begin
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check_results("start_in_run");
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_level: got %0b expected 1", done); end
    fill_random();
    fork
      run_map(0, NPIX);
      begin
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_cleared: got %0b expected 0", done); end
      end
    join
    check_results("second_map");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_stall();
    test_gaps();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
